// File: rtl/mem_bus_responder.sv
// Memory-side responder for the shared request/response bus: line reads and writes, one in service at a time.
// Optional MEMRESP_CRITWORD_EN: read bursts start at the addressed word and wrap within the line.

// state    | meaning
// IDLE     | waiting for a command-phase request beat
// RD_WAIT  | read accepted, counting down the programmed latency
// RD_BURST | presenting read beats, advancing on bus_respack
// WR_DATA  | accepting LINE_WORDS write-data beats into the line
module mem_bus_responder #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int MEM_WORDS      = 4096,
   parameter int LINE_WORDS     = 8,
   parameter int LATENCY        = 4,
   parameter int READ_SIGNAL    = 1,
   parameter int WRITE_SIGNAL   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_reqack,
   output logic                      bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   input  logic                      bus_respack
);

   localparam int IDX_BITS  = $clog2(MEM_WORDS);
   localparam int LINE_BITS = $clog2(LINE_WORDS);
   localparam int LN_BITS   = IDX_BITS - LINE_BITS;
   localparam int CNT_BITS  = $clog2(LATENCY + 1);
   localparam logic [LINE_BITS-1:0] LAST_BEAT = LINE_BITS'(LINE_WORDS - 1);
   localparam logic [1:0]           CMD_RD    = 2'(READ_SIGNAL);
   localparam logic [1:0]           CMD_WR    = 2'(WRITE_SIGNAL);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_DATA} state_t;

   logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

   state_t                    state_q, state_d;
   logic                      reqack_q, reqack_d;
   logic                      respcyc_q, respcyc_d;
   logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
   logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;
   logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
   logic [LN_BITS-1:0]        line_q, line_d;
   logic [CNT_BITS-1:0]       cnt_q, cnt_d;
   logic [LINE_BITS-1:0]      beat_q, beat_d;

   logic [1:0]                req_cmd;
   logic [LN_BITS-1:0]        req_line;
   logic                      req_take;
   logic [LINE_BITS-1:0]      fetch_beat;
   logic [LINE_BITS-1:0]      fetch_word;
   logic [BUS_DATA_WIDTH-1:0] fetch_data;
   logic                      mem_we;
   logic [IDX_BITS-1:0]       mem_waddr;

   assign req_cmd  = bus_reqtag[BUS_TAG_WIDTH-1 -: 2];
   assign req_line = bus_req[3 + LINE_BITS +: LN_BITS];
   // A beat is never sampled while our own ack is up, so each beat is taken exactly once.
   assign req_take = bus_reqcyc && !reqack_q;

   // Beat to fetch next: the first beat when leaving RD_WAIT, else the one after the current.
   assign fetch_beat = (state_q == RD_WAIT) ? '0 : beat_q + 1'b1;

`ifdef MEMRESP_CRITWORD_EN
   logic [LINE_BITS-1:0] off_q, off_d;
   logic [LINE_BITS-1:0] req_off;

   assign req_off    = bus_req[3 +: LINE_BITS];
   assign fetch_word = off_q + fetch_beat;
`else
   assign fetch_word = fetch_beat;
`endif

   assign fetch_data = mem[{line_q, fetch_word}];
   assign mem_waddr  = {line_q, beat_q};

   always_comb begin
      state_d   = state_q;
      reqack_d  = 1'b0;
      respcyc_d = respcyc_q;
      resp_d    = resp_q;
      resptag_d = resptag_q;
      tag_d     = tag_q;
      line_d    = line_q;
      cnt_d     = cnt_q;
      beat_d    = beat_q;
      mem_we    = 1'b0;
`ifdef MEMRESP_CRITWORD_EN
      off_d     = off_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_take) begin
               reqack_d = 1'b1;
               tag_d    = bus_reqtag;
               line_d   = req_line;
`ifdef MEMRESP_CRITWORD_EN
               off_d    = req_off;
`endif
               if (req_cmd == CMD_RD) begin
                  state_d = RD_WAIT;
                  cnt_d   = CNT_BITS'(LATENCY);
               end else if (req_cmd == CMD_WR) begin
                  state_d = WR_DATA;
                  beat_d  = '0;
               end
            end
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d   = RD_BURST;
               beat_d    = '0;
               respcyc_d = 1'b1;
               resp_d    = fetch_data;
               resptag_d = tag_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RD_BURST: begin
            if (bus_respack) begin
               if (beat_q == LAST_BEAT) begin
                  state_d   = IDLE;
                  respcyc_d = 1'b0;
               end else begin
                  beat_d = beat_q + 1'b1;
                  resp_d = fetch_data;
               end
            end
         end
         WR_DATA: begin
            if (req_take) begin
               mem_we   = !reset;
               reqack_d = 1'b1;
               beat_d   = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         reqack_q  <= 1'b0;
         respcyc_q <= 1'b0;
         resp_q    <= '0;
         resptag_q <= '0;
         tag_q     <= '0;
         line_q    <= '0;
         cnt_q     <= '0;
         beat_q    <= '0;
`ifdef MEMRESP_CRITWORD_EN
         off_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         reqack_q  <= reqack_d;
         respcyc_q <= respcyc_d;
         resp_q    <= resp_d;
         resptag_q <= resptag_d;
         tag_q     <= tag_d;
         line_q    <= line_d;
         cnt_q     <= cnt_d;
         beat_q    <= beat_d;
`ifdef MEMRESP_CRITWORD_EN
         off_q     <= off_d;
`endif
      end
   end

   // Backing store is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= bus_req;
   end

   assign bus_reqack  = reqack_q;
   assign bus_respcyc = respcyc_q;
   assign bus_resp    = resp_q;
   assign bus_resptag = resptag_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: line-level memory model plus an ordered
// queue of expected response beats, checked every cycle by one monitor process.
module tb_mem_bus_responder;

   logic        clk;
   logic        reset;
   logic        bus_reqcyc;
   logic [63:0] bus_req;
   logic [12:0] bus_reqtag;
   logic        bus_reqack;
   logic        bus_respcyc;
   logic [63:0] bus_resp;
   logic [12:0] bus_resptag;
   logic        bus_respack;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int ack_count = 0;

   typedef struct {
      logic [63:0] d;
      logic [12:0] t;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] model_mem [int];

   mem_bus_responder dut (
      .clk        (clk),
      .reset      (reset),
      .bus_reqcyc (bus_reqcyc),
      .bus_req    (bus_req),
      .bus_reqtag (bus_reqtag),
      .bus_reqack (bus_reqack),
      .bus_respcyc(bus_respcyc),
      .bus_resp   (bus_resp),
      .bus_resptag(bus_resptag),
      .bus_respack(bus_respack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every presented beat must match the head of the expected queue,
   // held beats must stay stable, and acks are single-cycle pulses.
   logic        prev_hold = 1'b0;
   logic        prev_ack  = 1'b0;
   logic [63:0] prev_data;
   logic [12:0] prev_tag;

   always @(negedge clk) begin
      if (prev_hold && !reset) begin
         check("hold_respcyc", bus_respcyc, 1'b1);
         check("hold_data", bus_resp, prev_data);
         check("hold_tag", bus_resptag, prev_tag);
      end
      if (bus_respcyc === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_beat", bus_respcyc, 1'b0);
         end else begin
            check("beat_data", bus_resp, exp_q[0].d);
            check("beat_tag", bus_resptag, exp_q[0].t);
            if (bus_respack) void'(exp_q.pop_front());
         end
      end
      if (bus_reqack === 1'b1) begin
         ack_count++;
         check("ack_single_cycle", prev_ack, 1'b0);
      end
      prev_ack  = (bus_reqack === 1'b1);
      prev_hold = (bus_respcyc === 1'b1) && !bus_respack && !reset;
      prev_data = bus_resp;
      prev_tag  = bus_resptag;
   end

   function automatic int word_idx(input logic [63:0] addr);
      return int'((addr >> 3) % 64'd4096);
   endfunction

   task automatic push_exp(input logic [63:0] addr, input logic [12:0] tag);
      int idx  = word_idx(addr);
      int base = idx & ~7;
      int off  = idx & 7;
      int w;
      exp_t e;
      for (int b = 0; b < 8; b++) begin
`ifdef MEMRESP_CRITWORD_EN
         w = (off + b) % 8;
`else
         w = b;
`endif
         e.d = model_mem[base + w];
         e.t = tag;
         exp_q.push_back(e);
      end
   endtask

   task automatic send_req(input logic [63:0] d, input logic [12:0] t);
      bit got = 0;
      bus_reqcyc = 1'b1;
      bus_req    = d;
      bus_reqtag = t;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (bus_reqack) begin
            got = 1;
            break;
         end
      end
      bus_reqcyc = 1'b0;
      if (!got) check("req_ack_timeout", 64'd0, 64'd1);
   endtask

   task automatic write_line(input logic [63:0] addr, input logic [10:0] id, input logic [63:0] d0);
      int a0   = ack_count;
      int base = word_idx(addr) & ~7;
      send_req(addr, {2'd2, id});
      for (int i = 0; i < 8; i++) begin
         send_req(d0 + 64'(i), {2'd2, id});
         model_mem[base + i] = d0 + 64'(i);
      end
      @(posedge clk); #1;
      check("write_ack_count", 64'(ack_count - a0), 64'd9);
   endtask

   task automatic read_line(input logic [63:0] addr, input logic [10:0] id,
                            input int stall_beat, input int stall_len,
                            output logic [63:0] first_data, output logic [12:0] first_tag,
                            output int held);
      int  ack_cyc;
      int  stall = 0;
      int  bi;
      bit  got = 0;
      push_exp(addr, {2'd1, id});
      send_req(addr, {2'd1, id});
      ack_cyc = cyc;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus_respcyc) begin
            got = 1;
            break;
         end
      end
      // Ack in cycle T, first beat in T + LATENCY + 1 with LATENCY = 4.
      check("read_latency", got ? 64'(cyc - ack_cyc) : 64'hFFFF, 64'd5);
      first_data = bus_resp;
      first_tag  = bus_resptag;
      held = 0;
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
         bi = 8 - exp_q.size();
         if (bi == stall_beat && stall < stall_len) begin
            bus_respack = 1'b0;
            stall++;
         end else begin
            bus_respack = 1'b1;
         end
         if (bus_respcyc && bi == stall_beat) held++;
         @(posedge clk); #1;
      end
      bus_respack = 1'b1;
      check("burst_drained", 64'(exp_q.size()), 64'd0);
      check("respcyc_after_burst", bus_respcyc, 1'b0);
   endtask

   logic [63:0] fd;
   logic [12:0] ft;
   int          held;
   int          a0;
   int          last_a;
   int          ack_b;
   bit          got;

   initial begin
      reset       = 1'b1;
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_reqack", bus_reqack, 1'b0);
      check("rst_respcyc", bus_respcyc, 1'b0);
      check("rst_resp", bus_resp, 64'd0);
      check("rst_resptag", bus_resptag, 13'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      write_line(64'h1000, 11'd5, 64'hA0);

      read_line(64'h1000, 11'd7, -1, 0, fd, ft, held);
      check("read_first_data", fd, 64'hA0);
      check("read_first_tag", ft, {2'd1, 11'd7});

      // Back-pressure: beat 2 held for 3 stalled cycles plus the consuming one.
      read_line(64'h1000, 11'd7, 2, 3, fd, ft, held);
      check("bp_first_data", fd, 64'hA0);
      check("bp_beat2_cycles", 64'(held), 64'd4);

      read_line(64'h1018, 11'd8, -1, 0, fd, ft, held);
`ifdef MEMRESP_CRITWORD_EN
      check("crit_first_data", fd, 64'hA3);
`else
      check("crit_first_data", fd, 64'hA0);
`endif

      // Reset in the middle of a burst.
      push_exp(64'h1000, {2'd1, 11'd7});
      send_req(64'h1000, {2'd1, 11'd7});
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus_respcyc) begin
            got = 1;
            break;
         end
      end
      check("rstburst_started", got, 1'b1);
      bus_respack = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      check("rstburst_respcyc", bus_respcyc, 1'b0);
      check("rstburst_reqack", bus_reqack, 1'b0);
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      bus_respack = 1'b1;
      read_line(64'h1000, 11'd7, -1, 0, fd, ft, held);
      check("post_rst_first_data", fd, 64'hA0);

      // Busy: a second read held during the first read's wait/burst.
      push_exp(64'h1000, {2'd1, 11'd3});
      push_exp(64'h1018, {2'd1, 11'd4});
      send_req(64'h1000, {2'd1, 11'd3});
      bus_reqcyc = 1'b1;
      bus_req    = 64'h1018;
      bus_reqtag = {2'd1, 11'd4};
      last_a = -1;
      ack_b  = -1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (last_a < 0 && exp_q.size() == 8) last_a = cyc - 1;
         if (bus_reqack) begin
            ack_b = cyc;
            break;
         end
      end
      bus_reqcyc = 1'b0;
      check("busy_ack_after_burst", (last_a >= 0 && ack_b >= 0) ? 64'(ack_b - last_a) : 64'hFFFF, 64'd2);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check("busy_second_drained", 64'(exp_q.size()), 64'd0);

      // Illegal command: acked once, no response.
      a0 = ack_count;
      send_req(64'h1000, {2'd3, 11'd9});
      repeat (12) begin
         @(posedge clk); #1;
      end
      check("illegal_ack_count", 64'(ack_count - a0), 64'd1);
      check("illegal_no_resp", bus_respcyc, 1'b0);
      read_line(64'h1008, 11'd2, -1, 0, fd, ft, held);
`ifdef MEMRESP_CRITWORD_EN
      check("after_illegal_data", fd, 64'hA1);
`else
      check("after_illegal_data", fd, 64'hA0);
`endif

      // Address wrap: 0x9000 aliases 0x1000 in a 4096-word store.
      write_line(64'h1000 + 64'(4096 * 8), 11'd6, 64'hB0);
      read_line(64'h1000, 11'd7, -1, 0, fd, ft, held);
      check("wrap_first_data", fd, 64'hB0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
